ka_142bit_seq_ctrl: RTL and testbench

- Area-reduced 142x142-bit GF(2) polynomial (carry-less) multiplier built around one shared 71-bit Karatsuba multiplier core (ka_71bit, 71x71 -> 141 bits).
- The controller sequences the three Karatsuba partial products through that core: low halves, high halves, then XOR-folded halves. It accumulates them into the 283-bit result with the standard overlap fold.
- Inputs and outputs use valid/ready handshakes.
- Sits where the fully parallel three-instance 142-bit multiplier would otherwise sit, for the area-constrained 283-bit field datapath.

---
 rtl/ka_142bit_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_ka_142bit_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ka_142bit_seq_ctrl.sv
// ka_142bit_seq_ctrl: 142x142-bit carry-less multiplier sequenced over one
// shared 71x71 Karatsuba core. The three partial products (low halves, high
// halves, XOR-folded halves) are taken in turn and folded into a 283-bit y.
module ka_142bit_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [141:0] a,
  input  logic [141:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [282:0] y,
  output logic         busy,
  output logic [70:0]  core_a,
  output logic [70:0]  core_b,
  input  logic [140:0] core_y
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [141:0]     r_a;
  logic [141:0]     r_b;
  logic [140:0]     r_p0;
  logic [140:0]     r_p2;
  logic [282:0]     r_y;
  logic [70:0]      r_core_a;
  logic [70:0]      r_core_b;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_last;
  logic [140:0]     w_mid;
  logic [282:0]     w_fold;

  // The low-half phase spends its first cycle loading the core operand
  // registers from r_a/r_b, so it waits one count longer than the other
  // two phases, whose operands are preloaded on the previous phase's last
  // count. That extra cycle is the "+1" in the 3*MUL_LAT+1 latency.
  assign w_last = (r_state == MUL_LO) ? (r_cnt == CNT_W'(MUL_LAT))
                                      : (r_cnt == CNT_W'(MUL_LAT - 1));

  // Karatsuba middle term: P1 arrives on core_y during the MUL_MID capture.
  assign w_mid  = r_p0 ^ core_y ^ r_p2;

  // Overlap fold; pure XOR, the [211:142] window takes both middle and high.
  assign w_fold = {142'b0, r_p0} ^ {71'b0, w_mid, 71'b0} ^ {r_p2, 142'b0};

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign y         = r_y;
  assign core_a    = r_core_a;
  assign core_b    = r_core_b;

  // Sequencer FSM with registered outputs and core operand registers.
  // NOTE: all state is updated with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_p0        <= '0;
      r_p2        <= '0;
      r_y         <= '0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_y        <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MUL_LO;
          end
        end
        MUL_LO: begin
          if (w_last) begin
            r_p0     <= core_y;
            r_cnt    <= '0;
            r_core_a <= r_a[141:71];
            r_core_b <= r_b[141:71];
            r_state  <= MUL_HI;
          end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_core_a <= r_a[70:0];
            r_core_b <= r_b[70:0];
          end
        end
        MUL_HI: begin
          if (w_last) begin
            r_p2     <= core_y;
            r_cnt    <= '0;
            r_core_a <= r_a[70:0] ^ r_a[141:71];
            r_core_b <= r_b[70:0] ^ r_b[141:71];
            r_state  <= MUL_MID;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MUL_MID: begin
          if (w_last) begin
            r_y         <= r_y ^ w_fold;
            r_cnt       <= '0;
            r_core_a    <= '0;
            r_core_b    <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ka_142bit_seq_ctrl.sv
// Testbench for ka_142bit_seq_ctrl: directed vectors on a MUL_LAT=1 instance
// with a combinational core, and a random back-to-back run on a MUL_LAT=3
// instance with a pipelined core model.
module tb_ka_142bit_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference bitwise carry-less products.
  function automatic logic [140:0] clmul71(input logic [70:0] x, input logic [70:0] z);
    logic [140:0] r;
    r = '0;
    for (int i = 0; i < 71; i++)
      if (z[i]) r = r ^ ({70'b0, x} << i);
    return r;
  endfunction

  function automatic logic [282:0] clmul142(input logic [141:0] x, input logic [141:0] z);
    logic [282:0] r;
    r = '0;
    for (int i = 0; i < 142; i++)
      if (z[i]) r = r ^ ({141'b0, x} << i);
    return r;
  endfunction

  // MUL_LAT=1 instance, combinational core.
  logic         rst1, iv1, ir1, ov1, or1, busy1;
  logic [141:0] a1, b1;
  logic [282:0] y1;
  logic [70:0]  ca1, cb1;
  logic [140:0] cy1;

  assign cy1 = clmul71(ca1, cb1);

  ka_142bit_seq_ctrl #(.MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .y(y1), .busy(busy1),
    .core_a(ca1), .core_b(cb1), .core_y(cy1)
  );

  // MUL_LAT=3 instance, core = combinational product followed by two stages.
  logic         rst3, iv3, ir3, ov3, or3, busy3;
  logic [141:0] a3, b3;
  logic [282:0] y3;
  logic [70:0]  ca3, cb3;
  logic [140:0] cy3, s1, s2;

  always @(posedge clk) begin
    s1 <= clmul71(ca3, cb3);
    s2 <= s1;
  end
  assign cy3 = s2;

  ka_142bit_seq_ctrl #(.MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .out_valid(ov3), .out_ready(or3), .y(y3), .busy(busy3),
    .core_a(ca3), .core_b(cb3), .core_y(cy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid on dut1; in_ready must stay low meanwhile.
  task automatic wait_done1(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ov1) begin
        lat = n;
        break;
      end
      n_cmp++;
      if (ir1 !== 1'b0 || busy1 !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_window: in_ready=%b busy=%b, want 0/1", ir1, busy1);
      end
    end
  endtask

  // One directed multiply on dut1 with immediate acceptance of the result.
  task automatic mul1(input logic [141:0] xa, input logic [141:0] xb,
                      input logic [282:0] exp, input string name);
    int lat;
    iv1 = 1'b1; a1 = xa; b1 = xb;
    step();
    iv1 = 1'b0; a1 = '1; b1 = '1;
    wait_done1(lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, want 4", name, lat);
    end
    n_cmp++;
    if (y1 !== exp) begin
      n_bad++;
      $display("FAIL %s_y: got %h want %h", name, y1, exp);
    end
    or1 = 1'b1;
    step();
    n_cmp++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b, want 0/1", name, ov1, ir1);
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    step(); step();
    rst1 = 1'b0; rst3 = 1'b0;
    n_cmp++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1/0/0", ir1, ov1, busy1);
    end
    n_cmp++;
    if (y1 !== '0 || ca1 !== '0 || cb1 !== '0) begin
      n_bad++;
      $display("FAIL reset_data: y=%h core_a=%h core_b=%h, want 0", y1, ca1, cb1);
    end
    n_cmp++;
    if (ir3 !== 1'b1 || ov3 !== 1'b0 || y3 !== '0) begin
      n_bad++;
      $display("FAIL reset_l3: in_ready=%b out_valid=%b y=%h", ir3, ov3, y3);
    end
  endtask

  task automatic test_basic();
    logic [282:0] e;
    logic [141:0] x;
    e = '0; e[0] = 1'b1;
    mul1(142'd1, 142'd1, e, "one_by_one");
    x = '0; x[71] = 1'b1; x[0] = 1'b1;
    e = '0; e[142] = 1'b1; e[0] = 1'b1;
    mul1(x, x, e, "mid_fold");
  endtask

  task automatic test_backpressure();
    logic [282:0] e;
    logic [141:0] x;
    int lat;
    x = '0; x[141] = 1'b1;
    e = '0; e[282] = 1'b1;
    or1 = 1'b0;
    iv1 = 1'b1; a1 = x; b1 = x;
    step();
    iv1 = 1'b0;
    wait_done1(lat);
    n_cmp++;
    if (lat !== 4 || y1 !== e) begin
      n_bad++;
      $display("FAIL top_bit: lat=%0d y=%h, want 4 and %h", lat, y1, e);
    end
    for (int k = 0; k < 5; k++) begin
      iv1 = (k == 2); a1 = 142'd1; b1 = 142'd1;
      step();
      n_cmp++;
      if (ov1 !== 1'b1 || ir1 !== 1'b0 || y1 !== e) begin
        n_bad++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b y=%h", k, ov1, ir1, y1);
      end
    end
    iv1 = 1'b0; or1 = 1'b1;
    step();
    n_cmp++;
    if (ov1 !== 1'b0 || ir1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL release: out_valid=%b in_ready=%b busy=%b, want 0/1/0", ov1, ir1, busy1);
    end
    step();
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_pulse: busy=%b, want 0", busy1);
    end
  endtask

  task automatic test_reset_mid();
    logic [282:0] e;
    iv1 = 1'b1; a1 = 142'd5; b1 = 142'd7;
    step();
    iv1 = 1'b0;
    step(); step();
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_abort_busy: busy=%b, want 1", busy1);
    end
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    n_cmp++;
    if (ov1 !== 1'b0 || y1 !== '0 || ir1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: out_valid=%b y=%h in_ready=%b busy=%b", ov1, y1, ir1, busy1);
    end
    e = 283'd5;
    mul1(142'd3, 142'd3, e, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [159:0] ra, rb;
    logic [282:0] e;
    int lat;
    or3 = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      ra = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom, $urandom};
      iv3 = 1'b1; a3 = ra[141:0]; b3 = rb[141:0];
      e = clmul142(ra[141:0], rb[141:0]);
      step();
      iv3 = 1'b0; a3 = '0; b3 = '0;
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
        step();
        if (ov3) begin
          lat = n;
          break;
        end
      end
      n_cmp++;
      if (lat !== 10) begin
        n_bad++;
        $display("FAIL rnd%0d_latency: got %0d want 10", t, lat);
      end
      n_cmp++;
      if (y3 !== e) begin
        n_bad++;
        $display("FAIL rnd%0d_y: got %h want %h", t, y3, e);
      end
      do begin
        or3 = 1'($urandom_range(0, 1));
        step();
        if (!or3) begin
          n_cmp++;
          if (ov3 !== 1'b1 || y3 !== e) begin
            n_bad++;
            $display("FAIL rnd%0d_hold: out_valid=%b y=%h", t, ov3, y3);
          end
        end
      end while (!or3);
      n_cmp++;
      if (ov3 !== 1'b0 || ir3 !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd%0d_release: out_valid=%b in_ready=%b", t, ov3, ir3);
      end
    end
  endtask

  // NOTE: bench inputs are driven with blocking assignments 1 time unit
  // after the rising edge, so the DUT always samples settled values.
  initial begin
    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
    rst3 = 1'b1; iv3 = 1'b0; or3 = 1'b1; a3 = '0; b3 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
